// File: rtl/rv_test_monitor.sv
// End-of-test monitor for riscv-tests runs: detects completion by retired-PC
// match or tohost store, decodes the result and guards the run with a watchdog.
module rv_test_monitor #(
  parameter int              XLEN        = 32,
  parameter int              MODE        = 0,
  parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
  parameter int              HOLD        = 2,
  parameter int              TIMEOUT     = 6000,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ret_valid,
  input  logic [XLEN-1:0]  ret_pc,
  input  logic [XLEN-1:0]  gp,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_num,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, FINISHED} state_t;

  localparam bit               WD_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] EXPIRE = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       HOLD_N = 4'(HOLD);

  state_t            state_reg, state_next;
  logic [3:0]        hold_reg, hold_next;
  logic [XLEN-1:0]   v_reg, v_next;
  logic [CNT_W-1:0]  cycles_reg, cycles_next;
  logic              done_reg, done_next;
  logic              passed_reg, passed_next;
  logic              failed_reg, failed_next;
  logic              timeout_reg, timeout_next;
  logic [XLEN-2:0]   fail_num_reg, fail_num_next;

  // Qualifying end-of-test event, its captured value and the hold-count update.
  logic              qual;
  logic [XLEN-1:0]   qual_val;
  logic [3:0]        hold_upd;

  generate
    if (MODE == 0) begin : g_pc_match
      logic       hit_pc;
      logic [3:0] hold_inc;
      always_comb begin
        hit_pc   = ret_valid && (ret_pc == PASS_PC);
        hold_inc = hold_reg + 4'd1;
        qual     = hit_pc && (hold_inc == HOLD_N);
        qual_val = gp;
        if (!ret_valid) begin
          hold_upd = hold_reg;
        end else if (hit_pc) begin
          hold_upd = hold_inc;
        end else begin
          hold_upd = 4'd0;
        end
      end
    end else begin : g_tohost
      always_comb begin
        qual     = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
        qual_val = st_data;
        hold_upd = hold_reg;
      end
    end
  endgenerate

  logic expire;
  assign expire = WD_EN && (cycles_reg == EXPIRE);

  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    v_next        = v_reg;
    cycles_next   = cycles_reg;
    done_next     = done_reg;
    passed_next   = passed_reg;
    failed_next   = failed_reg;
    timeout_next  = timeout_reg;
    fail_num_next = fail_num_reg;
    case (state_reg)
      IDLE, FINISHED: begin
        if (start) begin
          state_next    = RUN;
          hold_next     = 4'd0;
          cycles_next   = '0;
          done_next     = 1'b0;
          passed_next   = 1'b0;
          failed_next   = 1'b0;
          timeout_next  = 1'b0;
          fail_num_next = '0;
        end
      end
      RUN: begin
        hold_next = hold_upd;
        if (cycles_reg != '1) begin
          cycles_next = cycles_reg + 1'b1;
        end
        // A real completion beats a watchdog expiry in the same cycle.
        if (qual) begin
          v_next     = qual_val;
          state_next = CHECK;
        end else if (expire) begin
          cycles_next   = cycles_reg;
          timeout_next  = 1'b1;
          failed_next   = 1'b1;
          done_next     = 1'b1;
          fail_num_next = '0;
          state_next    = FINISHED;
        end
      end
      CHECK: begin
        done_next = 1'b1;
        if (v_reg == XLEN'(1)) begin
          passed_next = 1'b1;
        end else begin
          failed_next   = 1'b1;
          fail_num_next = v_reg[XLEN-1:1];
        end
        state_next = FINISHED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_reg     <= 4'd0;
      v_reg        <= '0;
      cycles_reg   <= '0;
      done_reg     <= 1'b0;
      passed_reg   <= 1'b0;
      failed_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      fail_num_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      v_reg        <= v_next;
      cycles_reg   <= cycles_next;
      done_reg     <= done_next;
      passed_reg   <= passed_next;
      failed_reg   <= failed_next;
      timeout_reg  <= timeout_next;
      fail_num_reg <= fail_num_next;
    end
  end

  assign busy     = (state_reg == RUN) || (state_reg == CHECK);
  assign done     = done_reg;
  assign passed   = passed_reg;
  assign failed   = failed_reg;
  assign timeout  = timeout_reg;
  assign fail_num = fail_num_reg;
  assign cycles   = cycles_reg;

endmodule
